// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and defaults for the two-port SRAM arbiter.
package sram_ctrl_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 7;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/sram_rr_arbiter_if.sv
// sram_rr_arbiter_if: two requester ports plus the single-port SRAM bus.
interface sram_rr_arbiter_if
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  p0_req_valid, p0_req_we, p0_req_ready, p0_rsp_valid;
    logic [ADDR_WIDTH-1:0] p0_req_addr;
    logic [DATA_WIDTH-1:0] p0_req_wdata, p0_rsp_rdata;
    logic                  p1_req_valid, p1_req_we, p1_req_ready, p1_rsp_valid;
    logic [ADDR_WIDTH-1:0] p1_req_addr;
    logic [DATA_WIDTH-1:0] p1_req_wdata, p1_rsp_rdata;
    logic                  csb0, web0, init_done;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0, dout0;

    modport slave (
        input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
        output p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
        input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
        output p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
        output csb0, web0, addr0, din0, init_done,
        input  dout0
    );
    modport master (
        output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
        output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
        input  csb0, web0, addr0, din0, init_done,
        output dout0
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; r_ptr names the port that wins a tie.
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_idx
);
    logic r_ptr;
    logic w_any;

    always_comb begin
        o_idx = (i_req[PORT0] & i_req[PORT1]) ? r_ptr : i_req[PORT1];
        w_any = i_en & |i_req;
        o_gnt = w_any ? (o_idx ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ptr <= PORT0;
        else if (w_any) r_ptr <= ~o_idx;
    end
endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: clears the SRAM after reset, then shares it between two
// requesters round-robin with registered SRAM controls and a 2-cycle read path.
module sram_rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input logic clk0,
    input logic rst0,
    sram_rr_arbiter_if.slave bus
);
    // One extra count value marks "last clear write issued", giving the idle step before RUN.
    localparam int CW = $clog2(RAM_DEPTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(RAM_DEPTH);

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_csb, r_web, w_cs, w_we, w_idx;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [DATA_WIDTH-1:0] r_din, w_din;
    logic [1:0]            w_gnt, w_rd, r_rd1, r_rd2;

    rr_arb2 u_arb (
        .clk   (clk0),
        .rst   (rst0),
        .i_en  (r_state == RUN),
        .i_req ({bus.p1_req_valid, bus.p0_req_valid}),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cs        = 1'b0;
        w_we        = 1'b0;
        w_addr      = r_addr;
        w_din       = r_din;
        w_rd        = w_gnt & ~{bus.p1_req_we, bus.p0_req_we};
        if (r_state == INIT) begin
            if (r_cnt == LAST_CNT) begin
                w_state_nxt = RUN;
            end else begin
                w_cs      = 1'b1;
                w_we      = 1'b1;
                w_addr    = ADDR_WIDTH'(r_cnt);
                w_din     = '0;
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (|w_gnt) begin
            w_cs   = 1'b1;
            w_we   = w_idx ? bus.p1_req_we    : bus.p0_req_we;
            w_addr = w_idx ? bus.p1_req_addr  : bus.p0_req_addr;
            w_din  = w_idx ? bus.p1_req_wdata : bus.p0_req_wdata;
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_addr  <= '0;
            r_din   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_csb   <= ~w_cs;
            r_web   <= ~w_we;
            r_addr  <= w_addr;
            r_din   <= w_din;
            r_rd1   <= w_rd;
            r_rd2   <= r_rd1;
        end
    end

    assign bus.csb0         = r_csb;
    assign bus.web0         = r_web;
    assign bus.addr0        = r_addr;
    assign bus.din0         = r_din;
    assign bus.init_done    = (r_state == RUN);
    assign bus.p0_req_ready = w_gnt[0];
    assign bus.p1_req_ready = w_gnt[1];
    assign bus.p0_rsp_valid = r_rd2[0];
    assign bus.p1_rsp_valid = r_rd2[1];
    assign bus.p0_rsp_rdata = bus.dout0;
    assign bus.p1_rsp_rdata = bus.dout0;
endmodule

// File: doc/sram_rr_arbiter.md
SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH, 32, word width; ADDR_WIDTH, 7, address width; RAM_DEPTH, 1<<ADDR_WIDTH, words cleared at init.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk0  in  1  single clock; all logic on rising edge
- rst0  in  1  reset, asynchronous, active-high
- p0_req_valid  in  1  port 0 request present
- p0_req_we  in  1  port 0: 1 = write, 0 = read
- p0_req_addr  in  ADDR_WIDTH  port 0 address
- p0_req_wdata  in  DATA_WIDTH  port 0 write data
- p0_req_ready  out  1  port 0 request accepted this cycle
- p0_rsp_valid  out  1  port 0 read data valid
- p0_rsp_rdata  out  DATA_WIDTH  port 0 read data
- p1_*  same seven signals for port 1
- csb0  out  1  SRAM chip select, active-low
- web0  out  1  SRAM write enable, active-low
- addr0  out  ADDR_WIDTH  SRAM address
- din0  out  DATA_WIDTH  SRAM write data
- dout0  in  DATA_WIDTH  SRAM read data, valid the cycle after a read is sampled
- init_done  out  1  high once the memory clear is complete

Function
REQ-003 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-004 In INIT, SHALL issue one write of all-zero data per cycle to addresses 0..RAM_DEPTH-1 in ascending order, using a counter; both req_ready outputs SHALL be 0.
REQ-005 After the write to RAM_DEPTH-1 is issued, SHALL enter RUN on the next edge and set init_done=1, holding it until reset.
REQ-006 In RUN, a port is eligible when its req_valid=1; req_ready SHALL be combinational and asserted for at most one port per cycle.
REQ-007 With one eligible port, that port SHALL be granted; with both eligible, the port not granted most recently SHALL be granted; after reset the priority pointer SHALL favour port 0.
REQ-008 The priority pointer SHALL update only on a grant; a losing requester SHALL be granted on the next cycle if it stays valid (no starvation, max wait 1 cycle).
REQ-009 A grant in cycle N SHALL register csb0=0, web0=~req_we, addr0, din0 so they are driven during cycle N+1; with no grant, csb0=1 and web0=1 in N+1, addr0/din0 hold their values.
REQ-010 A granted read in cycle N SHALL produce rsp_valid=1 on the same port for exactly cycle N+2, with rsp_rdata = dout0 passed through; rsp_rdata is don't-care while rsp_valid=0.
REQ-011 Writes SHALL produce no response; throughput is one request per cycle; back-to-back grants SHALL pipeline with no bubble.
REQ-012 A write followed by a read of the same address on the next grant SHALL return the new data, since the SRAM executes accesses in grant order.
REQ-013 Requesters SHALL hold valid, we, addr and wdata stable until ready; the arbiter SHALL NOT buffer unaccepted requests.

Reset
REQ-014 While rst0=1, SHALL force: csb0=1, web0=1, addr0=0, din0=0, all req_ready=0, all rsp_valid=0, init_done=0, init counter=0, priority pointer=port 0.
REQ-015 Reset asserted mid-INIT or mid-RUN SHALL drop in-flight reads, with no rsp_valid issued for them, and restart the full clear from address 0.

Structure
REQ-016 SHALL put the FSM state enum, DATA_WIDTH/ADDR_WIDTH defaults and the port-index constants in a shared package, sram_ctrl_pkg.
REQ-017 SHALL place the two-way round-robin decision (pointer register plus grant logic) in one sub-module, rr_arb2.

Verification
REQ-018 Release reset -> init_done rises exactly RAM_DEPTH+1 cycles later; 128 SRAM writes of 0x00000000 to addresses 0..127; no req_ready before that.
REQ-019 Port 0 writes 0xFACECAFE to address 10, then reads address 10 -> p0_rsp_valid pulses 2 cycles after the read grant with 0xFACECAFE; p1_rsp_valid stays 0.
REQ-020 Both ports hold read requests continuously (p0 addr 3, p1 addr 4) -> grants alternate 0,1,0,1 on consecutive cycles, one rsp_valid per cycle on alternating ports.
REQ-021 After init, read address 127 without any prior write -> rsp_rdata = 0x00000000.
REQ-022 Assert rst0 one cycle after a read grant -> no rsp_valid issued; csb0=1 immediately; init restarts at address 0.
REQ-023 Port 1 writes 0x12345678 to address 5 while port 0 reads address 5 in the same cycle (port 1 favoured) -> port 0's read is granted next cycle and returns 0x12345678.
